hsv_core_dmem_responder: RTL and testbench
==========================================

# hsv_core_dmem_responder

AXI4-Lite-style data-memory responder, the slave end of the core's data-memory port. Accepts read (AR) and write (AW/W) requests, serves them from an internal word-addressed SRAM with byte strobes, and returns read data (R) and write acknowledgements (B) in request order. Used as the tightly-coupled data RAM behind the memory unit and as the reference slave in core-level benches.

## Interface
- `DEPTH_WORDS`, 1024: SRAM size in 32-bit words, power of two.
- `RESP_DEPTH`, 4: response FIFO depth per channel (R and B), power of two, ≥2.
- `clk_core`  in  1  core clock.
- `rst_core_n`  in  1  reset; one clock, asynchronous, active-low.
- `dmem_ar_valid` / `dmem_ar_ready`  in/out  1  read address handshake.
- `dmem_ar_addr`  in  32  byte address of the read.
- `dmem_aw_valid` / `dmem_aw_ready`  in/out  1  write address handshake.
- `dmem_aw_addr`  in  32  byte address of the write.
- `dmem_w_valid` / `dmem_w_ready`  in/out  1  write data handshake.
- `dmem_w_data`  in  32  write data, lane-aligned.
- `dmem_w_strb`  in  4  byte enables.
- `dmem_r_valid` / `dmem_r_ready`  out/in  1  read response handshake.
- `dmem_r_data`  out  32  full word; subword extraction is the initiator's job.
- `dmem_r_resp`  out  `axi_resp_t`  OKAY / DECERR.
- `dmem_b_valid` / `dmem_b_ready`  out/in  1  write response handshake.
- `dmem_b_resp`  out  `axi_resp_t`  OKAY / DECERR.

## Operation
- Word index = `addr[log2(DEPTH_WORDS)+1:2]`; `addr[1:0]` ignored (initiator never issues misaligned requests).
- Read path: `rd_outstanding` counter (0..RESP_DEPTH) = accepted ARs not yet returned on R. `dmem_ar_ready = rd_outstanding != RESP_DEPTH`. On AR handshake, array read is registered and the word + resp pushed into the R FIFO. Counter +1 on AR handshake, −1 on R handshake, unchanged when both occur.
- Write path: AW and W each captured in a one-entry holding register; `awready`/`wready` high when its register is empty. Write performed when both registers are full (or being filled this cycle) and `wr_outstanding != RESP_DEPTH`; bytes with `strb=0` are untouched; both registers freed in that cycle; B entry pushed. `strb=0000` is a legal no-op write and still produces B OKAY.
- AW without W (or W without AW) waits indefinitely; no timeout.
- Read and write ports are independent; both may act in the same cycle. Same-word read and write in one cycle: read returns the old data (read-first).
- R responses in AR order; B responses in write order. No ordering between R and B.
- No flush input: every accepted request produces exactly one response.

## Timing
- Reset values: `ar_ready=1`, `aw_ready=1`, `w_ready=1`, `r_valid=0`, `b_valid=0`, `r_data=0`, `r_resp=OKAY`, `b_resp=OKAY`; counters and holding registers empty. SRAM contents not reset.
- Read latency: AR handshake in cycle N → `r_valid` high in N+1 if the R FIFO was empty.
- Write latency: AW and W handshake in the same cycle N → array updated at the end of N, `b_valid` in N+1. AW in N, W in N+k → `b_valid` in N+k+1.
- Throughput: one read and one write per cycle when R/B are drained every cycle.
- R/B outputs hold stable while `valid & ~ready`.
- Backpressure: with `r_ready=0`, exactly RESP_DEPTH ARs are accepted, then `ar_ready` drops in the cycle after the last accept; same for writes via `aw_ready`/`w_ready` once the holding registers fill.
- Reset asserted mid-operation: all in-flight requests and queued responses discarded; outputs return to reset values asynchronously.

## Configuration
- `HSV_DMEM_DECERR_EN` defined: addresses with any bit set in `addr[31:log2(DEPTH_WORDS)+2]` return DECERR; reads return `r_data=0`, writes leave the array unchanged.
- Undefined: upper address bits ignored; addresses alias modulo `DEPTH_WORDS*4`; resp is always OKAY.

## Test plan
- Write `0xDEADBEEF`, strb `1111` to `0x10`; then read `0x10` → `b_resp=OKAY` in N+1; `r_data=0xDEADBEEF`, `r_resp=OKAY` one cycle after AR.
- Byte strobe: word `0x10` = `0xDEADBEEF`, write `0x000000AA` with strb `0001` → readback `0xDEADBEAA`.
- AW in cycle 5, W in cycle 9 → single write, `b_valid` in cycle 10, no earlier B.
- Hold `r_ready=0` and issue 6 reads, RESP_DEPTH=4 → 4 accepted, `ar_ready=0`; release → 4 R beats in order, then remaining 2 accepted and returned.
- Same-cycle read and write to `0x20` (old `0x1`, new `0x2`) → read returns `0x1`; next read returns `0x2`.
- With `HSV_DMEM_DECERR_EN`, DEPTH_WORDS=1024: read `0x1000` → `r_resp=DECERR`, `r_data=0`. Without it: same read returns the contents of `0x0000` with OKAY.

Source files
------------

// File: rtl/hsv_core_dmem_responder.sv
// Data-memory responder: AXI4-Lite-style slave over a word-addressed SRAM with byte strobes.
// Optional build macro HSV_DMEM_DECERR_EN turns out-of-range addresses into DECERR responses.
package hsv_dmem_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_DECERR = 2'b11
  } axi_resp_t;
endpackage

module hsv_core_dmem_responder
  import hsv_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RESP_DEPTH  = 4
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        dmem_ar_valid,
  output logic        dmem_ar_ready,
  input  logic [31:0] dmem_ar_addr,
  input  logic        dmem_aw_valid,
  output logic        dmem_aw_ready,
  input  logic [31:0] dmem_aw_addr,
  input  logic        dmem_w_valid,
  output logic        dmem_w_ready,
  input  logic [31:0] dmem_w_data,
  input  logic [3:0]  dmem_w_strb,
  output logic        dmem_r_valid,
  input  logic        dmem_r_ready,
  output logic [31:0] dmem_r_data,
  output axi_resp_t   dmem_r_resp,
  output logic        dmem_b_valid,
  input  logic        dmem_b_ready,
  output axi_resp_t   dmem_b_resp
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RESP_DEPTH);

  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [31:0]      r_rq_data [RESP_DEPTH];
  axi_resp_t        r_rq_resp [RESP_DEPTH];
  logic [PTR_W-1:0] r_rq_wr, r_rq_rd;
  logic [CNT_W-1:0] r_rd_outstanding;

  axi_resp_t        r_bq_resp [RESP_DEPTH];
  logic [PTR_W-1:0] r_bq_wr, r_bq_rd;
  logic [CNT_W-1:0] r_wr_outstanding;

  logic             r_aw_full, r_w_full;
  logic [31:0]      r_aw_addr, r_w_data;
  logic [3:0]       r_w_strb;

  logic             w_ar_fire, w_r_fire, w_aw_fire, w_w_fire, w_b_fire;
  logic             w_wr_do, w_rd_err, w_wr_err, w_unused_addr;
  logic [31:0]      w_wr_addr, w_wr_data;
  logic [3:0]       w_wr_strb;
  logic [IDX_W-1:0] w_rd_idx, w_wr_idx;

  assign dmem_ar_ready = (r_rd_outstanding != CNT_FULL);
  assign dmem_aw_ready = ~r_aw_full;
  assign dmem_w_ready  = ~r_w_full;
  assign dmem_r_valid  = (r_rd_outstanding != '0);
  assign dmem_b_valid  = (r_wr_outstanding != '0);
  // Idle outputs are forced to zero/OKAY so they also read as reset values.
  assign dmem_r_data   = dmem_r_valid ? r_rq_data[r_rq_rd] : '0;
  assign dmem_r_resp   = dmem_r_valid ? r_rq_resp[r_rq_rd] : RESP_OKAY;
  assign dmem_b_resp   = dmem_b_valid ? r_bq_resp[r_bq_rd] : RESP_OKAY;

  assign w_ar_fire = dmem_ar_valid & dmem_ar_ready;
  assign w_r_fire  = dmem_r_valid  & dmem_r_ready;
  assign w_aw_fire = dmem_aw_valid & dmem_aw_ready;
  assign w_w_fire  = dmem_w_valid  & dmem_w_ready;
  assign w_b_fire  = dmem_b_valid  & dmem_b_ready;

  // A write may use a holding register or the value arriving this cycle.
  assign w_wr_addr = r_aw_full ? r_aw_addr : dmem_aw_addr;
  assign w_wr_data = r_w_full  ? r_w_data  : dmem_w_data;
  assign w_wr_strb = r_w_full  ? r_w_strb  : dmem_w_strb;
  assign w_wr_do   = (r_aw_full | w_aw_fire) & (r_w_full | w_w_fire) &
                     (r_wr_outstanding != CNT_FULL);

  assign w_rd_idx = dmem_ar_addr[IDX_W+1:2];
  assign w_wr_idx = w_wr_addr[IDX_W+1:2];

`ifdef HSV_DMEM_DECERR_EN
  assign w_rd_err      = |dmem_ar_addr[31:IDX_W+2];
  assign w_wr_err      = |w_wr_addr[31:IDX_W+2];
  assign w_unused_addr = ^{dmem_ar_addr[1:0], w_wr_addr[1:0]};
`else
  assign w_rd_err      = 1'b0;
  assign w_wr_err      = 1'b0;
  assign w_unused_addr = ^{dmem_ar_addr[31:IDX_W+2], dmem_ar_addr[1:0],
                           w_wr_addr[31:IDX_W+2], w_wr_addr[1:0]};
`endif

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_rq_wr          <= '0;
      r_rq_rd          <= '0;
      r_rd_outstanding <= '0;
      r_bq_wr          <= '0;
      r_bq_rd          <= '0;
      r_wr_outstanding <= '0;
      r_aw_full        <= 1'b0;
      r_w_full         <= 1'b0;
    end else begin
      if (w_ar_fire) r_rq_wr <= r_rq_wr + 1'b1;
      if (w_r_fire)  r_rq_rd <= r_rq_rd + 1'b1;
      case ({w_ar_fire, w_r_fire})
        2'b10:   r_rd_outstanding <= r_rd_outstanding + 1'b1;
        2'b01:   r_rd_outstanding <= r_rd_outstanding - 1'b1;
        default: ;
      endcase

      if (w_wr_do)  r_bq_wr <= r_bq_wr + 1'b1;
      if (w_b_fire) r_bq_rd <= r_bq_rd + 1'b1;
      case ({w_wr_do, w_b_fire})
        2'b10:   r_wr_outstanding <= r_wr_outstanding + 1'b1;
        2'b01:   r_wr_outstanding <= r_wr_outstanding - 1'b1;
        default: ;
      endcase

      if (w_wr_do) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end else begin
        if (w_aw_fire) r_aw_full <= 1'b1;
        if (w_w_fire)  r_w_full  <= 1'b1;
      end
    end
  end

  // NOTE: payload storage has no reset; the reset counters and full flags decide what is valid.
  always_ff @(posedge clk_core) begin
    if (w_ar_fire) begin
      r_rq_data[r_rq_wr] <= w_rd_err ? '0 : r_mem[w_rd_idx];
      r_rq_resp[r_rq_wr] <= w_rd_err ? RESP_DECERR : RESP_OKAY;
    end
    if (w_aw_fire) r_aw_addr <= dmem_aw_addr;
    if (w_w_fire) begin
      r_w_data <= dmem_w_data;
      r_w_strb <= dmem_w_strb;
    end
    if (w_wr_do) r_bq_resp[r_bq_wr] <= w_wr_err ? RESP_DECERR : RESP_OKAY;
  end

  // NOTE: non-blocking array writes let a same-edge read above see the old word (read-first).
  always_ff @(posedge clk_core) begin
    if (w_wr_do && !w_wr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_hsv_core_dmem_responder.sv
// Scoreboard bench for hsv_core_dmem_responder: stimulus pushes expected R/B beats,
// a negedge monitor pops and compares them as the DUT presents responses.
module tb_hsv_core_dmem_responder;
  import hsv_dmem_pkg::*;

  localparam int DEPTH_WORDS = 1024;
  localparam int RESP_DEPTH  = 4;

  logic        clk_core = 1'b0;
  logic        rst_core_n = 1'b0;
  logic        dmem_ar_valid, dmem_ar_ready;
  logic [31:0] dmem_ar_addr;
  logic        dmem_aw_valid, dmem_aw_ready;
  logic [31:0] dmem_aw_addr;
  logic        dmem_w_valid, dmem_w_ready;
  logic [31:0] dmem_w_data;
  logic [3:0]  dmem_w_strb;
  logic        dmem_r_valid, dmem_r_ready;
  logic [31:0] dmem_r_data;
  axi_resp_t   dmem_r_resp;
  logic        dmem_b_valid, dmem_b_ready;
  axi_resp_t   dmem_b_resp;

  always #5 clk_core = ~clk_core;

  hsv_core_dmem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk_core     (clk_core),
    .rst_core_n   (rst_core_n),
    .dmem_ar_valid(dmem_ar_valid),
    .dmem_ar_ready(dmem_ar_ready),
    .dmem_ar_addr (dmem_ar_addr),
    .dmem_aw_valid(dmem_aw_valid),
    .dmem_aw_ready(dmem_aw_ready),
    .dmem_aw_addr (dmem_aw_addr),
    .dmem_w_valid (dmem_w_valid),
    .dmem_w_ready (dmem_w_ready),
    .dmem_w_data  (dmem_w_data),
    .dmem_w_strb  (dmem_w_strb),
    .dmem_r_valid (dmem_r_valid),
    .dmem_r_ready (dmem_r_ready),
    .dmem_r_data  (dmem_r_data),
    .dmem_r_resp  (dmem_r_resp),
    .dmem_b_valid (dmem_b_valid),
    .dmem_b_ready (dmem_b_ready),
    .dmem_b_resp  (dmem_b_resp)
  );

  typedef struct {
    logic [31:0] data;
    axi_resp_t   resp;
  } r_exp_t;

  r_exp_t    exp_r[$];
  axi_resp_t exp_b[$];
  int        n_checks = 0;
  int        n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented R/B beat that is taken by the initiator.
  always @(negedge clk_core) begin : mon
    r_exp_t    er;
    axi_resp_t eb;
    if (rst_core_n) begin
      if (dmem_r_valid && dmem_r_ready) begin
        if (exp_r.size() == 0) check("r_unexpected_beat", 32'(dmem_r_valid), 32'd0);
        else begin
          er = exp_r.pop_front();
          check("r_data", dmem_r_data, er.data);
          check("r_resp", 32'(dmem_r_resp), 32'(er.resp));
        end
      end
      if (dmem_b_valid && dmem_b_ready) begin
        if (exp_b.size() == 0) check("b_unexpected_beat", 32'(dmem_b_valid), 32'd0);
        else begin
          eb = exp_b.pop_front();
          check("b_resp", 32'(dmem_b_resp), 32'(eb));
        end
      end
    end
  end

  // All request tasks start and end at posedge+1.
  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input axi_resp_t rs);
    int n = 0;
    exp_r.push_back('{data: d, resp: rs});
    dmem_ar_valid = 1'b1;
    dmem_ar_addr  = a;
    do begin @(negedge clk_core); n++; end while (!dmem_ar_ready && n < 200);
    if (!dmem_ar_ready) check("ar_handshake", 32'(dmem_ar_ready), 32'd1);
    @(posedge clk_core); #1;
    dmem_ar_valid = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] a);
    int n = 0;
    dmem_aw_valid = 1'b1;
    dmem_aw_addr  = a;
    do begin @(negedge clk_core); n++; end while (!dmem_aw_ready && n < 200);
    if (!dmem_aw_ready) check("aw_handshake", 32'(dmem_aw_ready), 32'd1);
    @(posedge clk_core); #1;
    dmem_aw_valid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    dmem_w_valid = 1'b1;
    dmem_w_data  = d;
    dmem_w_strb  = s;
    do begin @(negedge clk_core); n++; end while (!dmem_w_ready && n < 200);
    if (!dmem_w_ready) check("w_handshake", 32'(dmem_w_ready), 32'd1);
    @(posedge clk_core); #1;
    dmem_w_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input axi_resp_t rs);
    int n = 0;
    exp_b.push_back(rs);
    dmem_aw_valid = 1'b1;
    dmem_aw_addr  = a;
    dmem_w_valid  = 1'b1;
    dmem_w_data   = d;
    dmem_w_strb   = s;
    do begin @(negedge clk_core); n++; end
      while (!(dmem_aw_ready && dmem_w_ready) && n < 200);
    if (!(dmem_aw_ready && dmem_w_ready))
      check("aw_w_handshake", 32'(dmem_aw_ready && dmem_w_ready), 32'd1);
    @(posedge clk_core); #1;
    dmem_aw_valid = 1'b0;
    dmem_w_valid  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 100) begin
      @(posedge clk_core); #1; n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dmem_ar_valid = 1'b0; dmem_ar_addr = '0;
    dmem_aw_valid = 1'b0; dmem_aw_addr = '0;
    dmem_w_valid  = 1'b0; dmem_w_data  = '0; dmem_w_strb = '0;
    dmem_r_ready  = 1'b1; dmem_b_ready = 1'b1;

    repeat (2) @(posedge clk_core);
    #1 rst_core_n = 1'b1;
    @(negedge clk_core);
    check("rst_ar_ready", 32'(dmem_ar_ready), 32'd1);
    check("rst_aw_ready", 32'(dmem_aw_ready), 32'd1);
    check("rst_w_ready",  32'(dmem_w_ready),  32'd1);
    check("rst_r_valid",  32'(dmem_r_valid),  32'd0);
    check("rst_b_valid",  32'(dmem_b_valid),  32'd0);
    check("rst_r_data",   dmem_r_data,        32'd0);
    check("rst_r_resp",   32'(dmem_r_resp),   32'd0);
    check("rst_b_resp",   32'(dmem_b_resp),   32'd0);
    @(posedge clk_core); #1;

    // Full-word write then readback, with one-cycle latencies.
    do_write(32'h10, 32'hDEAD_BEEF, 4'b1111, RESP_OKAY);
    check("b_latency", 32'(dmem_b_valid), 32'd1);
    do_read(32'h10, 32'hDEAD_BEEF, RESP_OKAY);
    check("r_latency", 32'(dmem_r_valid), 32'd1);

    // Byte strobes, and an all-zero strobe no-op write.
    do_write(32'h10, 32'h0000_00AA, 4'b0001, RESP_OKAY);
    do_read(32'h10, 32'hDEAD_BEAA, RESP_OKAY);
    do_write(32'h10, 32'hFFFF_FFFF, 4'b0000, RESP_OKAY);
    do_read(32'h10, 32'hDEAD_BEAA, RESP_OKAY);

    // AW first, W four cycles later: B only after W.
    exp_b.push_back(RESP_OKAY);
    do_aw(32'h30);
    check("aw_ready_held", 32'(dmem_aw_ready), 32'd0);
    repeat (3) begin
      @(negedge clk_core);
      check("no_early_b", 32'(dmem_b_valid), 32'd0);
    end
    @(posedge clk_core); #1;
    do_w(32'h1234_5678, 4'b1111);
    check("b_after_w", 32'(dmem_b_valid), 32'd1);
    check("aw_ready_freed", 32'(dmem_aw_ready), 32'd1);
    do_read(32'h30, 32'h1234_5678, RESP_OKAY);

    // Read backpressure: four accepted, then ar_ready drops until R drains.
    for (int i = 0; i < 6; i++)
      do_write(32'h40 + 32'(4*i), 32'h1000_0000 + 32'(i), 4'b1111, RESP_OKAY);
    drain();
    dmem_r_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      do_read(32'h40 + 32'(4*i), 32'h1000_0000 + 32'(i), RESP_OKAY);
    check("ar_ready_full", 32'(dmem_ar_ready), 32'd0);
    fork
      begin
        do_read(32'h50, 32'h1000_0004, RESP_OKAY);
        do_read(32'h54, 32'h1000_0005, RESP_OKAY);
      end
      begin
        repeat (3) begin
          @(negedge clk_core);
          check("ar_ready_stall", 32'(dmem_ar_ready), 32'd0);
          check("r_data_stable", dmem_r_data, 32'h1000_0000);
        end
        @(posedge clk_core); #1;
        dmem_r_ready = 1'b1;
      end
    join
    drain();

    // Write backpressure: four B entries plus one held write, then aw/w ready drop.
    dmem_b_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      do_write(32'h60 + 32'(4*i), 32'h77 + 32'(i), 4'b1111, RESP_OKAY);
    check("aw_ready_full", 32'(dmem_aw_ready), 32'd0);
    check("w_ready_full",  32'(dmem_w_ready),  32'd0);
    @(posedge clk_core); #1;
    dmem_b_ready = 1'b1;
    drain();
    do_read(32'h70, 32'h0000_007B, RESP_OKAY);

    // Same-cycle read and write of one word: read-first.
    do_write(32'h20, 32'h1, 4'b1111, RESP_OKAY);
    exp_r.push_back('{data: 32'h1, resp: RESP_OKAY});
    exp_b.push_back(RESP_OKAY);
    dmem_ar_valid = 1'b1; dmem_ar_addr = 32'h20;
    dmem_aw_valid = 1'b1; dmem_aw_addr = 32'h20;
    dmem_w_valid  = 1'b1; dmem_w_data  = 32'h2; dmem_w_strb = 4'b1111;
    @(negedge clk_core);
    check("rw_same_cycle_ready",
          32'(dmem_ar_ready && dmem_aw_ready && dmem_w_ready), 32'd1);
    @(posedge clk_core); #1;
    dmem_ar_valid = 1'b0; dmem_aw_valid = 1'b0; dmem_w_valid = 1'b0;
    do_read(32'h20, 32'h2, RESP_OKAY);

    // Out-of-range addresses: DECERR or modulo aliasing depending on build.
    do_write(32'h0, 32'hCAFE_F00D, 4'b1111, RESP_OKAY);
    do_write(32'h4, 32'h1111_1111, 4'b1111, RESP_OKAY);
`ifdef HSV_DMEM_DECERR_EN
    do_read(32'h1000, 32'h0, RESP_DECERR);
    do_write(32'h1004, 32'h55, 4'b1111, RESP_DECERR);
    do_read(32'h4, 32'h1111_1111, RESP_OKAY);
`else
    do_read(32'h1000, 32'hCAFE_F00D, RESP_OKAY);
    do_write(32'h1004, 32'h55, 4'b1111, RESP_OKAY);
    do_read(32'h4, 32'h0000_0055, RESP_OKAY);
`endif
    drain();
    check("r_queue_drained", 32'(exp_r.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);

    // Asynchronous reset with responses queued: everything discarded at once.
    dmem_r_ready  = 1'b0;
    dmem_ar_valid = 1'b1; dmem_ar_addr = 32'h10;
    repeat (2) @(posedge clk_core);
    #1 dmem_ar_valid = 1'b0;
    @(negedge clk_core);
    check("pre_reset_r_valid", 32'(dmem_r_valid), 32'd1);
    #2 rst_core_n = 1'b0;
    #1;
    check("async_rst_r_valid",  32'(dmem_r_valid),  32'd0);
    check("async_rst_r_data",   dmem_r_data,        32'd0);
    check("async_rst_ar_ready", 32'(dmem_ar_ready), 32'd1);
    @(posedge clk_core); #1;
    rst_core_n   = 1'b1;
    dmem_r_ready = 1'b1;
    repeat (3) begin
      @(negedge clk_core);
      check("post_rst_r_valid", 32'(dmem_r_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
